axis_rd: RTL

- MCU read-back path for one motor axis; the read-side counterpart of the axis command write register block.
- Decodes an MCU read cycle and returns one status byte on Dout.
- Snapshots the 16-bit current position so the two bytes read back are coherent.
- Holds clear-on-read sticky event flags; one instance per axis, selected by the upper address bits.

---
 rtl/axis_rd.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/axis_rd.sv
// -----------------------------------------------------------------------------
// axis_rd : MCU read-back path for one motor axis.
//
// Decodes an asynchronous MCU read cycle (RdN low) aimed at this axis and
// returns one registered status byte on Dout while DoutEn is high.
//
// Register map (Addr[2:0], latched at the start of a read):
//   0 : CurPos[7:0]       (also snapshots CurPos[15:8] into the PosHi shadow)
//   1 : PosHi shadow      (not refreshed by this read)
//   2 : AxisState[7:0]
//   3 : AxisState[15:8]
//   4 : sticky {4'b0, LimNHit, LimPHit, MoveDoneF, SpdDoneF}, clear-on-read
//   5 : {LimitN_sync, LimitP_sync, PlsBusy, 1'b0, VERSION}
//   6 : TsShadow[7:0]  when AXIS_RD_TIMESTAMP_EN is defined, else 8'h00
//   7 : TsShadow[15:8] when AXIS_RD_TIMESTAMP_EN is defined, else 8'h00
//
// Optional feature macro: AXIS_RD_TIMESTAMP_EN
//   Adds a 16-bit free-running counter whose value is captured alongside the
//   PosHi snapshot on an address-0 read.
//
// Ports:
//   Clk          in   system clock, all state on posedge
//   Rst          in   asynchronous active-high reset
//   Addr[7:0]    in   [7:3] axis select, [2:0] register select
//   RdN          in   MCU read strobe, active low, asynchronous
//   CurPos[15:0] in   live position counter
//   AxisState    in   live 16-bit axis state word
//   PlsBusy      in   pulse generator busy level
//   MoveDone     in   one-Clk pulse at end of move
//   SpeedSetDone in   one-Clk pulse when a speed load completes
//   LimitP/N     in   limit switches, asynchronous levels
//   Dout[7:0]    out  registered read data
//   DoutEn       out  high while this instance drives the MCU bus
//
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module axis_rd #(
    parameter logic [4:0] AXIS_BASE   = 5'h00,
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] VERSION     = 4'h1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  Addr,
    input  logic        RdN,
    input  logic [15:0] CurPos,
    input  logic [15:0] AxisState,
    input  logic        PlsBusy,
    input  logic        MoveDone,
    input  logic        SpeedSetDone,
    input  logic        LimitP,
    input  logic        LimitN,
    output logic [7:0]  Dout,
    output logic        DoutEn
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             dout_q, dout_d;
    logic                   dout_en_q, dout_en_d;
    logic [2:0]             addr_lat_q, addr_lat_d;
    logic [7:0]             pos_hi_q, pos_hi_d;
    logic [3:0]             flags_q, flags_d;

    logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
    logic                   rd_prev_q, rd_prev_d;
    logic [SYNC_STAGES-1:0] rd_valid_q, rd_valid_d;
    logic                   rd_armed_q, rd_armed_d;
    logic [SYNC_STAGES-1:0] limp_sync_q, limp_sync_d;
    logic                   limp_prev_q, limp_prev_d;
    logic [SYNC_STAGES-1:0] limn_sync_q, limn_sync_d;
    logic                   limn_prev_q, limn_prev_d;

`ifdef AXIS_RD_TIMESTAMP_EN
    logic [15:0]            ts_cnt_q, ts_cnt_d;
    logic [15:0]            ts_shadow_q, ts_shadow_d;
`endif

    logic       rd_sync;
    logic       limp_sync;
    logic       limn_sync;
    logic       rd_fall;
    logic       rd_rise;
    logic       limp_rise;
    logic       limn_rise;
    logic       addr_match;
    logic [3:0] flag_set;
    logic [7:0] rd_byte;

    assign rd_sync   = rd_sync_q[SYNC_STAGES-1];
    assign limp_sync = limp_sync_q[SYNC_STAGES-1];
    assign limn_sync = limn_sync_q[SYNC_STAGES-1];

    // The reset value of the RdN chain is 1, so if the MCU is still holding
    // RdN low when reset releases, the first real sample would look like a
    // fresh falling edge. rd_armed_q only allows a fall once a genuine high
    // level has been seen, which makes a read interrupted by reset harmless.
    assign rd_fall   = rd_armed_q & rd_prev_q & ~rd_sync;
    assign rd_rise   = ~rd_prev_q & rd_sync;
    assign limp_rise = limp_sync & ~limp_prev_q;
    assign limn_rise = limn_sync & ~limn_prev_q;

    assign addr_match = (Addr[7:3] == AXIS_BASE);
    assign flag_set   = {limn_rise, limp_rise, MoveDone, SpeedSetDone};

    assign Dout   = dout_q;
    assign DoutEn = dout_en_q;

    // Read data selection from the live address; only sampled into Dout on
    // the edge that starts a read.
    always_comb begin
        rd_byte = 8'h00;
        case (Addr[2:0])
            3'd0: rd_byte = CurPos[7:0];
            3'd1: rd_byte = pos_hi_q;
            3'd2: rd_byte = AxisState[7:0];
            3'd3: rd_byte = AxisState[15:8];
            3'd4: rd_byte = {4'b0000, flags_q};
            3'd5: rd_byte = {limn_sync, limp_sync, PlsBusy, 1'b0, VERSION};
`ifdef AXIS_RD_TIMESTAMP_EN
            3'd6: rd_byte = ts_shadow_q[7:0];
            3'd7: rd_byte = ts_shadow_q[15:8];
`else
            3'd6: rd_byte = 8'h00;
            3'd7: rd_byte = 8'h00;
`endif
            default: rd_byte = 8'h00;
        endcase
    end

    // Next-state logic: synchronisers, read FSM and sticky flags.
    always_comb begin
        rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], RdN};
        rd_prev_d   = rd_sync;
        rd_valid_d  = {rd_valid_q[SYNC_STAGES-2:0], 1'b1};
        rd_armed_d  = rd_armed_q | (rd_valid_q[SYNC_STAGES-1] & rd_sync);
        limp_sync_d = {limp_sync_q[SYNC_STAGES-2:0], LimitP};
        limp_prev_d = limp_sync;
        limn_sync_d = {limn_sync_q[SYNC_STAGES-2:0], LimitN};
        limn_prev_d = limn_sync;

        state_d    = state_q;
        dout_d     = dout_q;
        dout_en_d  = dout_en_q;
        addr_lat_d = addr_lat_q;
        pos_hi_d   = pos_hi_q;
        flags_d    = flags_q;
`ifdef AXIS_RD_TIMESTAMP_EN
        ts_cnt_d    = ts_cnt_q + 16'd1;
        ts_shadow_d = ts_shadow_q;
`endif

        case (state_q)
            IDLE: begin
                if (rd_fall && addr_match) begin
                    addr_lat_d = Addr[2:0];
                    dout_d     = rd_byte;
                    dout_en_d  = 1'b1;
                    state_d    = READ;
                    if (Addr[2:0] == 3'd0) begin
                        pos_hi_d = CurPos[15:8];
`ifdef AXIS_RD_TIMESTAMP_EN
                        ts_shadow_d = ts_cnt_q;
`endif
                    end
                end
            end
            READ: begin
                if (rd_rise) begin
                    dout_en_d = 1'b0;
                    state_d   = IDLE;
                    if (addr_lat_q == 3'd4) begin
                        flags_d = 4'b0000;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Applied after the clear so a coincident event is never lost.
        flags_d = flags_d | flag_set;
    end

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            dout_q      <= 8'h00;
            dout_en_q   <= 1'b0;
            addr_lat_q  <= 3'd0;
            pos_hi_q    <= 8'h00;
            flags_q     <= 4'b0000;
            rd_sync_q   <= '1;
            rd_prev_q   <= 1'b1;
            rd_valid_q  <= '0;
            rd_armed_q  <= 1'b0;
            limp_sync_q <= '0;
            limp_prev_q <= 1'b0;
            limn_sync_q <= '0;
            limn_prev_q <= 1'b0;
`ifdef AXIS_RD_TIMESTAMP_EN
            ts_cnt_q    <= 16'h0000;
            ts_shadow_q <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            dout_q      <= dout_d;
            dout_en_q   <= dout_en_d;
            addr_lat_q  <= addr_lat_d;
            pos_hi_q    <= pos_hi_d;
            flags_q     <= flags_d;
            rd_sync_q   <= rd_sync_d;
            rd_prev_q   <= rd_prev_d;
            rd_valid_q  <= rd_valid_d;
            rd_armed_q  <= rd_armed_d;
            limp_sync_q <= limp_sync_d;
            limp_prev_q <= limp_prev_d;
            limn_sync_q <= limn_sync_d;
            limn_prev_q <= limn_prev_d;
`ifdef AXIS_RD_TIMESTAMP_EN
            ts_cnt_q    <= ts_cnt_d;
            ts_shadow_q <= ts_shadow_d;
`endif
        end
    end

endmodule
